param_up_down_counter: RTL and testbench

Parametrised synchronous up/down counter. It is the clocked successor to the team's fixed 4-bit combinational incrementer: width and terminal value are configurable, and it adds direction, parallel load, count enable, wrap/saturate mode and a registered wrap pulse. Lab designs use it as a general sequencing counter, for example as a decade counter, a timer, or an address generator.

---
 rtl/param_up_down_counter.sv | 86 ++++++++
 tb/tb_param_up_down_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
// Parametrised synchronous up/down counter with parallel load, wrap/saturate
// ends and a registered one-cycle wrap pulse.
module param_up_down_counter #(
  parameter int unsigned       WIDTH    = 4,
  parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
  parameter bit                SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};

  logic [WIDTH:0]   inc_carry;
  logic [WIDTH:0]   dec_borrow;
  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH-1:0] dec_diff;
  logic [WIDTH:0]   inc_full;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign inc_carry[0]  = 1'b1;
  assign dec_borrow[0] = 1'b1;

  // Half-adder / half-subtractor ripple chains, carry-in tied to 1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign inc_sum[i]       = count[i] ^ inc_carry[i];
    assign inc_carry[i+1]   = count[i] & inc_carry[i];
    assign dec_diff[i]      = count[i] ^ dec_borrow[i];
    assign dec_borrow[i+1]  = ~count[i] & dec_borrow[i];
  end

  // Carry-out kept so count+1 at all-ones cannot alias below MAX_VAL.
  assign inc_full = {inc_carry[WIDTH], inc_sum};

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = ({1'b0, load_val} > MAX_EXT) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (inc_full > MAX_EXT) begin
          if (!SATURATE) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = inc_full[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the top bit means the count was zero.
        if (dec_borrow[WIDTH]) begin
          if (!SATURATE) begin
            count_next = MAX_VAL;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = dec_diff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Bench for param_up_down_counter: three configurations driven side by side
// and checked every cycle against an integer reference model.
module tb_param_up_down_counter;

  logic       clk;
  logic [2:0] rst_n_v;
  logic [2:0] en_v;
  logic [2:0] up_v;
  logic [2:0] load_v;
  logic [7:0] lv [3];

  logic [3:0] c0, c1;
  logic [7:0] c2;
  logic [2:0] wrap_v, at_max_v, at_zero_v;

  int tests_run;
  int tests_failed;

  // Reference model state
  int mc [3];
  int mw [3];
  int maxv [3] = '{9, 15, 255};
  int wd   [3] = '{4, 4, 8};
  bit sat  [3] = '{1'b0, 1'b1, 1'b0};

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dec (
    .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
    .load_val(lv[0][3:0]), .count(c0), .wrap(wrap_v[0]), .at_max(at_max_v[0]),
    .at_zero(at_zero_v[0])
  );

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
    .load_val(lv[1][3:0]), .count(c1), .wrap(wrap_v[1]), .at_max(at_max_v[1]),
    .at_zero(at_zero_v[1])
  );

  param_up_down_counter #(.WIDTH(8)) u_byte (
    .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
    .load_val(lv[2]), .count(c2), .wrap(wrap_v[2]), .at_max(at_max_v[2]),
    .at_zero(at_zero_v[2])
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int act_count(int k);
    case (k)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  // Model: the counter's rules in plain integer arithmetic.
  function automatic void model_step(int k);
    int v;
    if (!rst_n_v[k]) begin
      mc[k] = 0;
      mw[k] = 0;
    end else if (load_v[k]) begin
      v = int'(lv[k]) % (1 << wd[k]);
      mc[k] = (v > maxv[k]) ? maxv[k] : v;
      mw[k] = 0;
    end else if (en_v[k]) begin
      mw[k] = 0;
      if (up_v[k]) begin
        if (mc[k] < maxv[k]) mc[k] = mc[k] + 1;
        else if (!sat[k]) begin mc[k] = 0; mw[k] = 1; end
      end else begin
        if (mc[k] > 0) mc[k] = mc[k] - 1;
        else if (!sat[k]) begin mc[k] = maxv[k]; mw[k] = 1; end
      end
    end else begin
      mw[k] = 0;
    end
  endfunction

  task automatic check_all(string tag);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      assert (act_count(k) === mc[k]) else begin
        tests_failed++;
        $error("FAIL %s count[%0d] observed=%0d expected=%0d", tag, k, act_count(k), mc[k]);
      end
      tests_run++;
      assert (int'(wrap_v[k]) === mw[k]) else begin
        tests_failed++;
        $error("FAIL %s wrap[%0d] observed=%0d expected=%0d", tag, k, wrap_v[k], mw[k]);
      end
      tests_run++;
      assert (at_max_v[k] === (mc[k] == maxv[k])) else begin
        tests_failed++;
        $error("FAIL %s at_max[%0d] observed=%0d expected=%0d", tag, k, at_max_v[k], mc[k] == maxv[k]);
      end
      tests_run++;
      assert (at_zero_v[k] === (mc[k] == 0)) else begin
        tests_failed++;
        $error("FAIL %s at_zero[%0d] observed=%0d expected=%0d", tag, k, at_zero_v[k], mc[k] == 0);
      end
    end
  endtask

  // Driver tasks
  task automatic idle_all();
    rst_n_v = 3'b111;
    en_v    = 3'b000;
    up_v    = 3'b000;
    load_v  = 3'b000;
    for (int k = 0; k < 3; k++) lv[k] = 8'h00;
  endtask

  task automatic tick(string tag);
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_load(int k, int val, string tag);
    idle_all();
    load_v[k] = 1'b1;
    lv[k]     = 8'(val);
    tick(tag);
  endtask

  task automatic do_reset(string tag);
    idle_all();
    rst_n_v = 3'b000;
    tick(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < 3; k++) begin mc[k] = 0; mw[k] = 0; end
    idle_all();

    // Reset state
    do_reset("reset");

    // Decade counter up through the wrap
    idle_all();
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    repeat (12) tick("decade_up");
    tests_run++;
    assert (c0 === 4'd2) else begin
      tests_failed++;
      $error("FAIL decade_end observed=%0d expected=2", c0);
    end

    // Down from reset wraps to MAX_VAL
    do_reset("reset2");
    idle_all();
    en_v[0] = 1'b1; up_v[0] = 1'b0;
    tick("decade_down_wrap");
    tests_run++;
    assert (c0 === 4'd9 && wrap_v[0] === 1'b1) else begin
      tests_failed++;
      $error("FAIL down_wrap observed=%0d/%0d expected=9/1", c0, wrap_v[0]);
    end
    repeat (2) tick("decade_down");

    // Saturating counter at both ends
    do_load(1, 14, "sat_load");
    idle_all();
    en_v[1] = 1'b1; up_v[1] = 1'b1;
    repeat (4) tick("sat_up");
    do_load(1, 0, "sat_load0");
    idle_all();
    en_v[1] = 1'b1; up_v[1] = 1'b0;
    repeat (3) tick("sat_down");

    // Clamped load beats enable, then wraps on the next up edge
    idle_all();
    load_v[0] = 1'b1; lv[0] = 8'd13; en_v[0] = 1'b1; up_v[0] = 1'b1;
    tick("clamp_load");
    idle_all();
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    tick("clamp_wrap");

    // Reset mid-count beats a simultaneous load
    do_reset("reset3");
    idle_all();
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    repeat (6) tick("count_to_6");
    rst_n_v[0] = 1'b0; load_v[0] = 1'b1; lv[0] = 8'd3;
    tick("reset_vs_load");
    idle_all();
    up_v[0] = 1'b1;
    repeat (5) tick("hold_after_reset");

    // Byte counter wrap from 0xFE, then full load sweep
    do_load(2, 8'hFE, "byte_load");
    idle_all();
    en_v[2] = 1'b1; up_v[2] = 1'b1;
    repeat (2) tick("byte_up");
    for (int v = 0; v < 256; v++) do_load(2, v, "byte_sweep");

    // Out-of-range loads on the decade counter
    for (int v = 0; v < 16; v++) do_load(0, v, "decade_sweep");

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) begin
        rst_n_v[k] = ($urandom_range(0, 24) != 0);
        load_v[k]  = ($urandom_range(0, 7) == 0);
        en_v[k]    = ($urandom_range(0, 3) != 0);
        up_v[k]    = ($urandom_range(0, 2) != 0);
        lv[k]      = 8'($urandom_range(0, 255));
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
